// File: rtl/mem_2r1w_if.sv
// Request/response bundle for the 2R1W storage core: one write port with
// read-back, plus two independent read ports.
interface mem_2r1w_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              en_w0;
  logic [ADDR_W-1:0] w0_addr;
  logic [DATA_W-1:0] d0;
  logic [ADDR_W-1:0] r1_addr;
  logic [ADDR_W-1:0] r2_addr;
  logic [DATA_W-1:0] d1;
  logic [DATA_W-1:0] d2;
  logic [DATA_W-1:0] dw;

  modport master (
    output en_w0, w0_addr, d0, r1_addr, r2_addr,
    input  d1, d2, dw
  );

  modport slave (
    input  en_w0, w0_addr, d0, r1_addr, r2_addr,
    output d1, d2, dw
  );
endinterface

// File: rtl/mem_2r1w_core.sv
// 2R1W storage core: three write-replicated 1R1W banks (r1, r2, write read-back)
// and a per-entry valid vector so reset clears the whole array at once.
module mem_2r1w_core #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048
) (
  input  logic        clk,
  input  logic        rst,
  mem_2r1w_if.slave   bus
);

  // Unwritten (invalid) entries read as zero regardless of stale bank data.
  function automatic logic [DATA_W-1:0] mask_invalid(input logic vld,
                                                     input logic [DATA_W-1:0] data);
    return vld ? data : '0;
  endfunction

  logic [DATA_W-1:0] bank_a [DEPTH];
  logic [DATA_W-1:0] bank_b [DEPTH];
  logic [DATA_W-1:0] bank_c [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  logic [DATA_W-1:0] rd_a_p1;
  logic [DATA_W-1:0] rd_b_p1;
  logic [DATA_W-1:0] rd_c_p1;
  logic              vld_a_p1;
  logic              vld_b_p1;
  logic              vld_c_p1;

  logic              wr_go;
  assign wr_go = bus.en_w0 && !rst;

  // Stage p0 -> p1: bank reads are read-first; the same edge's write lands
  // in the array but the read registers capture the old contents.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      bank_a[bus.w0_addr] <= bus.d0;
      bank_b[bus.w0_addr] <= bus.d0;
      bank_c[bus.w0_addr] <= bus.d0;
    end
    rd_a_p1 <= bank_a[bus.r1_addr];
    rd_b_p1 <= bank_b[bus.r2_addr];
    rd_c_p1 <= bank_c[bus.w0_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (bus.en_w0) begin
      valid_q[bus.w0_addr] <= 1'b1;
    end
  end

  // Valid lookup registered alongside the bank read; clearing these on reset
  // forces all outputs to zero without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_a_p1 <= 1'b0;
      vld_b_p1 <= 1'b0;
      vld_c_p1 <= 1'b0;
    end else begin
      vld_a_p1 <= valid_q[bus.r1_addr];
      vld_b_p1 <= valid_q[bus.r2_addr];
      vld_c_p1 <= valid_q[bus.w0_addr];
    end
  end

  assign bus.d1 = mask_invalid(vld_a_p1, rd_a_p1);
  assign bus.d2 = mask_invalid(vld_b_p1, rd_b_p1);
  assign bus.dw = mask_invalid(vld_c_p1, rd_c_p1);

endmodule
